memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Shares the single-ported RAM between the instruction and data request paths of the datapath's cache interface.
- Registered grant FSM holds one requester on the RAM until it completes, aborts or times out.
- Data has priority; a streak limiter prevents instruction starvation.
- A timeout watchdog guards against RAM that never responds.

Parameters:
- DSTREAK_MAX, 4: maximum consecutive data grants while an instruction request is pending.
- TIMEOUT, 16: cycles a grant may wait for ramstate==ACCESS before it is abandoned.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- iwait  out  1  instruction not yet serviced
- iload  out  32  instruction read data
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- dwait  out  1  data not yet serviced
- dload  out  32  data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- timeout  out  1  one-cycle pulse when a grant is abandoned

Behaviour:
- Reset is nRST, asynchronous, active-low; clock is CLK.
- Reset state:
  - state=IDLE, dstreak=0, tcnt=0.
  - Outputs: ram* enables=0, ramaddr=0, ramstore=0, timeout=0.
  - iwait=1 when iREN=1, dwait=1 when dREN|dWEN=1.
  - iload=ramload, dload=ramload (pass-through at all times).
- States: IDLE, IGRANT, DGRANT.
- IDLE:
  - All ram enables are 0; nothing is granted.
  - Next-state selection:
    - If dREN|dWEN and not (iREN and dstreak==DSTREAK_MAX): go to DGRANT.
    - Else if iREN: go to IGRANT.
    - Else stay in IDLE.
  - Minimum latency is 1 cycle of arbitration, then the grant cycle(s).
- IGRANT:
  - Outputs: ramREN=iREN, ramWEN=0, ramaddr=iaddr, ramstore=0.
  - iwait = iREN and not (ramstate==ACCESS).
- DGRANT:
  - Outputs: ramWEN=dWEN, ramREN=dREN and not dWEN (write wins if both are asserted), ramaddr=daddr, ramstore=dstore.
  - dwait = (dREN|dWEN) and not (ramstate==ACCESS).
- The ungranted requester sees wait=1 whenever its request is asserted.
- Completion: in a grant state with ramstate==ACCESS:
  - The requester's wait is 0 that cycle; it samples load on that edge.
  - Next state is IDLE.
  - On a data completion: dstreak increments, saturating at DSTREAK_MAX, only if iREN=1 at completion; otherwise dstreak=0.
  - On an instruction completion: dstreak=0.
- Abort: if the granted requester deasserts its request mid-grant:
  - ram enables drop combinationally in the same cycle.
  - Next state is IDLE, tcnt=0, and there is no completion bookkeeping.
- ramstate==ERROR or BUSY: the grant is held and the request is re-presented. No retry count other than the timeout.
- Timeout watchdog:
  - tcnt increments each grant cycle without ACCESS and clears on entry to IDLE.
  - When tcnt==TIMEOUT-1 and there is no ACCESS: timeout=1 for that one cycle and next state is IDLE.
  - On a timeout, wait remains 1 and the requester re-arbitrates normally.
- IDLE always inserts one dead cycle between back-to-back grants, so there are no combinational grant paths from IDLE.
- Reset mid-grant: everything returns to reset values immediately and any in-flight RAM access is dropped.

Decomposition:
- Belongs in cpu_types_pkg:
  - ramstate_t (FREE/BUSY/ACCESS/ERROR), already present.
  - word_t, already present.
  - New enum arb_state_t {IDLE, IGRANT, DGRANT}.
- Single module; no sub-module. The watchdog counter and streak counter stay inline.

Test Plan:
- Instruction fetch only: iREN=1, iaddr=0x40, ramstate goes ACCESS on the 2nd grant cycle with ramload=0x8C220004 -> ramREN=1, ramaddr=0x40 in IGRANT; iwait=0 for exactly one cycle with iload=0x8C220004; then IDLE.
- Simultaneous requests: iREN=1 and dWEN=1, daddr=0x100, dstore=0xDEADBEEF, ACCESS after 1 cycle -> DGRANT first with ramWEN=1, ramstore=0xDEADBEEF; then IDLE; then IGRANT serves the fetch.
- Starvation guard: iREN held high, data requests back-to-back, DSTREAK_MAX=4 -> four data completions, then IGRANT even though the data request is still pending; dstreak=0 afterwards.
- Timeout: dREN=1, ramstate held BUSY -> after 16 grant cycles timeout pulses once; state goes to IDLE; dwait stays 1; a new DGRANT starts next arbitration.
- Abort and ERROR: dREN deasserted on the 2nd DGRANT cycle -> ramREN=0 that cycle, next state IDLE; separately, ramstate=ERROR for 3 cycles then ACCESS -> grant held, one completion, no timeout.
- Reset: nRST pulsed low mid-DGRANT -> all ram enables 0 asynchronously; state IDLE; counters 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, machine word and arbiter grant states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Shares the single-ported RAM between instruction and data paths. Data wins
// arbitration, a streak limiter protects fetches, and a watchdog abandons stuck grants.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DSTREAK_MAX = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        timeout
);

  localparam int SW = $clog2(DSTREAK_MAX + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] SMAX  = SW'(DSTREAK_MAX);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  arb_state_t    state, next_state;
  logic [SW-1:0] dstreak, next_dstreak;
  logic [TW-1:0] tcnt, next_tcnt;
  logic          dreq, access, granted_req, tmo_hit;

  assign dreq        = dREN | dWEN;
  assign access      = (ramstate == 2'(ACCESS));
  assign granted_req = (state == IGRANT) ? iREN : ((state == DGRANT) ? dreq : 1'b0);
  assign tmo_hit     = granted_req && !access && (tcnt == TLAST);
  assign iload       = ramload;
  assign dload       = ramload;

  // State, streak and watchdog registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      dstreak <= '0;
      tcnt    <= '0;
    end else begin
      state   <= next_state;
      dstreak <= next_dstreak;
      tcnt    <= next_tcnt;
    end
  end

  // Arbitration and grant-release decisions
  always_comb begin
    next_state   = state;
    next_dstreak = dstreak;
    next_tcnt    = tcnt;
    case (state)
      IDLE: begin
        next_tcnt = '0;
        if (dreq && !(iREN && (dstreak == SMAX))) begin
          next_state = DGRANT;
        end else if (iREN) begin
          next_state = IGRANT;
        end else begin
          next_state = IDLE;
        end
      end
      IGRANT, DGRANT: begin
        if (!granted_req || access || tmo_hit) begin
          next_state = IDLE;
          next_tcnt  = '0;
          // Only a real completion moves the streak; aborts and timeouts leave it alone
          if (granted_req && access) begin
            if ((state == DGRANT) && iREN) begin
              next_dstreak = (dstreak == SMAX) ? SMAX : dstreak + SW'(1);
            end else begin
              next_dstreak = '0;
            end
          end else begin
            next_dstreak = dstreak;
          end
        end else begin
          next_state = state;
          next_tcnt  = tcnt + TW'(1);
        end
      end
      default: begin
        next_state   = IDLE;
        next_tcnt    = '0;
        next_dstreak = '0;
      end
    endcase
  end

  // RAM drive and wait flags follow the current grant and live request
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0000_0000;
    ramstore = 32'h0000_0000;
    iwait    = iREN;
    dwait    = dreq;
    timeout  = tmo_hit;
    case (state)
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = iREN && !access;
      end
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN && !dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = dreq && !access;
      end
      default: begin
        ramREN = 1'b0;
        ramWEN = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a latency-programmable RAM model answers
// grants, and every completion is compared against the expected service order.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef struct packed {
    logic        is_d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait, ramREN, ramWEN, timeout;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_icomp  = 0;
  int          n_dcomp  = 0;
  int          n_tmo    = 0;
  int          ram_lat  = 99;
  logic [1:0]  ram_busy = RS_BUSY;
  int          gcnt;
  exp_t        sb[$];

  memory_arbiter #(.DSTREAK_MAX(4), .TIMEOUT(16)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .timeout(timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h8C22_0004;
    return a ^ 32'hA5A5_0000;
  endfunction

  // RAM model: counts enabled cycles and answers ACCESS once the programmed latency elapses
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) gcnt <= 0;
    else if (ramREN | ramWEN) gcnt <= gcnt + 1;
    else gcnt <= 0;
  end

  assign ramstate = (ramREN | ramWEN) ? ((gcnt == ram_lat) ? RS_ACCESS : ram_busy) : RS_FREE;
  assign ramload  = mem_rd(ramaddr);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    #1;
  endtask

  // Completion monitor: pops the scoreboard whenever a requester's wait drops
  always @(negedge CLK) begin
    exp_t e;
    if (nRST) begin
      if (timeout) n_tmo++;
      if (iREN && !iwait) begin
        n_icomp++;
        if (sb.size() == 0) check_eq("sb_depth_i", 32'(sb.size()), 32'd1);
        else begin
          e = sb.pop_front();
          check_eq("order_i", {31'd0, e.is_d}, 32'd0);
          check_eq("iaddr_ram", ramaddr, e.addr);
          check_eq("iload", iload, e.data);
        end
      end
      if ((dREN | dWEN) && !dwait) begin
        n_dcomp++;
        if (sb.size() == 0) check_eq("sb_depth_d", 32'(sb.size()), 32'd1);
        else begin
          e = sb.pop_front();
          check_eq("order_d", {31'd0, e.is_d}, 32'd1);
          check_eq("daddr_ram", ramaddr, e.addr);
          if (e.wr) begin
            check_eq("dwrite_en", {31'd0, ramWEN}, 32'd1);
            check_eq("dstore_ram", ramstore, e.data);
          end else begin
            check_eq("dload", dload, e.data);
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int i0, d0, guard;
    nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
    #2;
    check_eq("rst_ramREN", {31'd0, ramREN}, 32'd0);
    check_eq("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    check_eq("rst_ramaddr", ramaddr, 32'h0);
    check_eq("rst_ramstore", ramstore, 32'h0);
    check_eq("rst_timeout", {31'd0, timeout}, 32'd0);
    check_eq("rst_iwait", {31'd0, iwait}, 32'd1);
    check_eq("rst_dwait", {31'd0, dwait}, 32'd1);
    check_eq("rst_iload", iload, 32'hA5A5_0000);
    iREN = 1'b0; dREN = 1'b0;
    cyc(); cyc();
    nRST = 1'b1;
    cyc();

    // Instruction fetch only
    ram_lat = 1; ram_busy = RS_BUSY;
    sb.push_back('{1'b0, 1'b0, 32'h40, 32'h8C22_0004});
    iREN = 1'b1; iaddr = 32'h40;
    #1 check_eq("f_idle_ren", {31'd0, ramREN}, 32'd0);
    cyc();
    check_eq("f_ren", {31'd0, ramREN}, 32'd1);
    check_eq("f_addr", ramaddr, 32'h40);
    check_eq("f_iwait1", {31'd0, iwait}, 32'd1);
    cyc();
    check_eq("f_iwait0", {31'd0, iwait}, 32'd0);
    cyc();
    check_eq("f_iwait_after", {31'd0, iwait}, 32'd1);
    check_eq("f_idle_after", {31'd0, ramREN}, 32'd0);
    iREN = 1'b0;
    cyc();

    // Simultaneous requests: data (write beats read) first, then the fetch
    sb.push_back('{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF});
    sb.push_back('{1'b0, 1'b0, 32'h44, mem_rd(32'h44)});
    iREN = 1'b1; iaddr = 32'h44;
    dWEN = 1'b1; dREN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    cyc();
    check_eq("s_wen", {31'd0, ramWEN}, 32'd1);
    check_eq("s_ren_wr_wins", {31'd0, ramREN}, 32'd0);
    check_eq("s_addr", ramaddr, 32'h100);
    check_eq("s_store", ramstore, 32'hDEAD_BEEF);
    check_eq("s_iwait", {31'd0, iwait}, 32'd1);
    cyc();
    check_eq("s_dwait0", {31'd0, dwait}, 32'd0);
    dWEN = 1'b0; dREN = 1'b0;
    cyc();
    check_eq("s_dead_cycle", {31'd0, ramREN | ramWEN}, 32'd0);
    cyc();
    check_eq("s_igrant", {31'd0, ramREN}, 32'd1);
    check_eq("s_iaddr", ramaddr, 32'h44);
    cyc();
    check_eq("s_iwait0", {31'd0, iwait}, 32'd0);
    iREN = 1'b0;
    cyc();

    // Starvation guard: two rounds of four data grants then one fetch
    ram_lat = 0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) sb.push_back('{1'b1, 1'b0, 32'h200, mem_rd(32'h200)});
      sb.push_back('{1'b0, 1'b0, 32'h48, mem_rd(32'h48)});
    end
    i0 = n_icomp; d0 = n_dcomp; guard = 0;
    iREN = 1'b1; iaddr = 32'h48; dREN = 1'b1; daddr = 32'h200;
    while ((n_icomp < i0 + 2) && (guard < 80)) begin
      cyc();
      guard++;
    end
    iREN = 1'b0; dREN = 1'b0;
    check_eq("st_icomp", 32'(n_icomp - i0), 32'd2);
    check_eq("st_dcomp", 32'(n_dcomp - d0), 32'd8);
    cyc();

    // Timeout with RAM stuck BUSY
    ram_lat = 99; ram_busy = RS_BUSY;
    dREN = 1'b1; daddr = 32'h300;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      check_eq("t_pulse", {31'd0, timeout}, (c == 16) ? 32'd1 : 32'd0);
      check_eq("t_dwait", {31'd0, dwait}, 32'd1);
      check_eq("t_ren", {31'd0, ramREN}, 32'd1);
    end
    cyc();
    check_eq("t_idle_ren", {31'd0, ramREN}, 32'd0);
    check_eq("t_idle_tmo", {31'd0, timeout}, 32'd0);
    check_eq("t_idle_dwait", {31'd0, dwait}, 32'd1);
    cyc();
    check_eq("t_regrant", {31'd0, ramREN}, 32'd1);
    ram_lat = 1;
    sb.push_back('{1'b1, 1'b0, 32'h300, mem_rd(32'h300)});
    cyc();
    check_eq("t_done", {31'd0, dwait}, 32'd0);
    dREN = 1'b0;
    cyc();
    check_eq("t_release", {31'd0, ramREN}, 32'd0);

    // Abort on the second grant cycle
    ram_lat = 99;
    dREN = 1'b1; daddr = 32'h400;
    cyc();
    check_eq("a_ren1", {31'd0, ramREN}, 32'd1);
    cyc();
    check_eq("a_ren2", {31'd0, ramREN}, 32'd1);
    dREN = 1'b0;
    #1 check_eq("a_drop", {31'd0, ramREN}, 32'd0);
    cyc();
    check_eq("a_idle", {31'd0, ramREN | ramWEN}, 32'd0);

    // ERROR for three cycles then ACCESS
    d0 = n_dcomp;
    ram_lat = 3; ram_busy = RS_ERROR;
    sb.push_back('{1'b1, 1'b0, 32'h500, mem_rd(32'h500)});
    dREN = 1'b1; daddr = 32'h500;
    for (int c = 0; c < 3; c++) begin
      cyc();
      check_eq("e_hold", {31'd0, ramREN}, 32'd1);
      check_eq("e_dwait", {31'd0, dwait}, 32'd1);
    end
    cyc();
    check_eq("e_done", {31'd0, dwait}, 32'd0);
    dREN = 1'b0;
    cyc();
    check_eq("e_one_comp", 32'(n_dcomp - d0), 32'd1);
    check_eq("e_release", {31'd0, ramREN}, 32'd0);

    // Reset asserted mid-grant
    ram_lat = 99; ram_busy = RS_BUSY;
    dWEN = 1'b1; daddr = 32'h600; dstore = 32'h1234_5678;
    cyc();
    check_eq("r_wen", {31'd0, ramWEN}, 32'd1);
    nRST = 1'b0;
    #1;
    check_eq("r_wen_drop", {31'd0, ramWEN}, 32'd0);
    check_eq("r_addr", ramaddr, 32'h0);
    check_eq("r_store", ramstore, 32'h0);
    check_eq("r_dwait", {31'd0, dwait}, 32'd1);
    dWEN = 1'b0;
    cyc();
    nRST = 1'b1;
    ram_lat = 0;
    sb.push_back('{1'b0, 1'b0, 32'h80, mem_rd(32'h80)});
    iREN = 1'b1; iaddr = 32'h80;
    #1 check_eq("r_idle", {31'd0, ramREN | ramWEN}, 32'd0);
    cyc();
    check_eq("r_fetch_grant", {31'd0, ramREN}, 32'd1);
    check_eq("r_fetch_done", {31'd0, iwait}, 32'd0);
    iREN = 1'b0;
    cyc();

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    check_eq("tmo_count", 32'(n_tmo), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
